// File: rtl/quadrilatero_pkg.sv
// Shared systolic-array types: issued instruction, weight-load FSM states, array geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package quadrilatero_pkg;

    localparam int SA_N_ROWS = 4;
    localparam int SA_RLEN   = 128;
    localparam int SA_N_REGS = 8;
    localparam int SA_REG_W  = $clog2(SA_N_REGS);

    // Issued systolic-array instruction; rs2 names the weight matrix register.
    typedef struct packed {
        logic [3:0]          opcode;
        logic [SA_REG_W-1:0] rd;
        logic [SA_REG_W-1:0] rs1;
        logic [SA_REG_W-1:0] rs2;
    } sa_instr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        HANDOFF = 2'd2
    } wl_state_e;

endpackage

// File: rtl/quadrilatero_sa_weight_load_stage_if.sv
// Bundles the weight-load stage handshakes: issue, register-file read, shadow-buffer write, FF handoff.
// Latency: n/a (wires only).
// Backpressure: rf_gnt_i stalls requests, ff_ready_i stalls the handoff; start_i has no ready of its own beyond wl_ready_o.
interface quadrilatero_sa_weight_load_stage_if
    import quadrilatero_pkg::*;
#(
    parameter int N_ROWS = SA_N_ROWS,
    parameter int RLEN   = SA_RLEN,
    parameter int N_REGS = SA_N_REGS
) ();

    logic                      start_i;
    sa_instr_t                 instr_i;
    logic                      wl_ready_o;
    logic                      rf_req_o;
    logic [$clog2(N_REGS)-1:0] rf_reg_o;
    logic [$clog2(N_ROWS)-1:0] rf_row_o;
    logic                      rf_gnt_i;
    logic                      rf_rvalid_i;
    logic [RLEN-1:0]           rf_rdata_i;
    logic                      weight_valid_o;
    logic [$clog2(N_ROWS)-1:0] weight_row_o;
    logic [RLEN-1:0]           weight_data_o;
    logic                      ff_valid_o;
    sa_instr_t                 ff_instr_o;
    logic                      ff_ready_i;

    // Stage side.
    modport master (
        input  start_i, instr_i, rf_gnt_i, rf_rvalid_i, rf_rdata_i, ff_ready_i,
        output wl_ready_o, rf_req_o, rf_reg_o, rf_row_o,
               weight_valid_o, weight_row_o, weight_data_o, ff_valid_o, ff_instr_o
    );

    // Environment side (issue queue, register file, shadow buffer, FF stage).
    modport slave (
        output start_i, instr_i, rf_gnt_i, rf_rvalid_i, rf_rdata_i, ff_ready_i,
        input  wl_ready_o, rf_req_o, rf_reg_o, rf_row_o,
               weight_valid_o, weight_row_o, weight_data_o, ff_valid_o, ff_instr_o
    );

endinterface

// File: rtl/quadrilatero_sa_weight_load_stage.sv
// Weight-load stage: reads N_ROWS weight rows of instr.rs2 from the RF and streams them to the shadow buffer.
// Latency: first request 1 cycle after start, FF handoff N_ROWS+2 cycles after start with no stalls.
// Backpressure: rf_gnt_i low holds the request; ff_ready_i low holds the handoff and keeps wl_ready_o low.
module quadrilatero_sa_weight_load_stage
    import quadrilatero_pkg::*;
#(
    parameter int N_ROWS = SA_N_ROWS,
    parameter int RLEN   = SA_RLEN,
    parameter int N_REGS = SA_N_REGS
) (
    input  logic clk_i,
    input  logic rst_i,
    quadrilatero_sa_weight_load_stage_if.master bus
);

    localparam int CNT_W = $clog2(N_ROWS + 1);
    localparam int ROW_W = $clog2(N_ROWS);
    localparam int REG_W = $clog2(N_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_ROWS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    wl_state_e        state_q,   state_d;
    logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
    sa_instr_t        instr_q,   instr_d;

    logic rf_req;
    logic weight_valid;
    logic ff_valid;
    logic wl_ready;

    // Next-state, counter and handshake decode; a response only counts when it has an outstanding request.
    always_comb begin
        state_d      = state_q;
        req_cnt_d    = req_cnt_q;
        rsp_cnt_d    = rsp_cnt_q;
        instr_d      = instr_q;
        rf_req       = 1'b0;
        weight_valid = 1'b0;
        ff_valid     = 1'b0;
        wl_ready     = 1'b0;
        case (state_q)
            IDLE: begin
                wl_ready = !rst_i;
                if (bus.start_i) begin
                    instr_d   = bus.instr_i;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                rf_req = (req_cnt_q < CNT_MAX);
                if (rf_req && bus.rf_gnt_i) begin
                    req_cnt_d = req_cnt_q + CNT_ONE;
                end
                if (bus.rf_rvalid_i && (rsp_cnt_q != req_cnt_q)) begin
                    weight_valid = 1'b1;
                    rsp_cnt_d    = rsp_cnt_q + CNT_ONE;
                end
                if (rsp_cnt_d == CNT_MAX) begin
                    state_d = HANDOFF;
                end
            end
            HANDOFF: begin
                ff_valid = 1'b1;
                if (bus.ff_ready_i) begin
                    wl_ready = !rst_i;
                    if (bus.start_i) begin
                        instr_d   = bus.instr_i;
                        req_cnt_d = '0;
                        rsp_cnt_d = '0;
                        state_d   = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and instruction latch; synchronous reset returns to an empty IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            instr_q   <= instr_d;
        end
    end

    assign bus.wl_ready_o     = wl_ready;
    assign bus.rf_req_o       = rf_req;
    assign bus.rf_reg_o       = REG_W'(instr_q.rs2);
    assign bus.rf_row_o       = req_cnt_q[ROW_W-1:0];
    assign bus.weight_valid_o = weight_valid;
    assign bus.weight_row_o   = rsp_cnt_q[ROW_W-1:0];
    // Read data goes straight to the shadow buffer; weight_valid_o qualifies it.
    assign bus.weight_data_o  = bus.rf_rdata_i;
    assign bus.ff_valid_o     = ff_valid;
    assign bus.ff_instr_o     = instr_q;

endmodule

// File: tb/tb_quadrilatero_sa_weight_load_stage.sv
// Directed bench for the weight-load stage with an in-order, one-cycle register-file responder.
// Latency: n/a.
// Backpressure: exercises grant stalls and FF-stage stalls.
module tb_quadrilatero_sa_weight_load_stage;
    import quadrilatero_pkg::*;

    localparam int N_ROWS = SA_N_ROWS;
    localparam int RLEN   = SA_RLEN;
    localparam int N_REGS = SA_N_REGS;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    quadrilatero_sa_weight_load_stage_if #(.N_ROWS(N_ROWS), .RLEN(RLEN), .N_REGS(N_REGS)) bus ();

    quadrilatero_sa_weight_load_stage #(.N_ROWS(N_ROWS), .RLEN(RLEN), .N_REGS(N_REGS)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Responder state: a request granted this cycle returns data next cycle.
    logic       pend     = 1'b0;
    logic [1:0] pend_row = 2'd0;

    function automatic logic [127:0] rowdat(input int r);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(r);
        return {4{w}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs just after the rising edge, leave outputs to settle until the falling edge.
    task automatic do_cycle(input logic rst, input logic st, input sa_instr_t ins,
                            input logic gnt, input logic frdy, input logic frv);
        @(posedge clk_i);
        #1;
        rst_i           = rst;
        bus.start_i     = st;
        bus.instr_i     = ins;
        bus.rf_gnt_i    = gnt;
        bus.ff_ready_i  = frdy;
        bus.rf_rvalid_i = pend | frv;
        bus.rf_rdata_i  = pend ? RLEN'(rowdat(int'(pend_row))) : RLEN'(128'hDEAD);
        @(negedge clk_i);
        pend     = bus.rf_req_o & gnt;
        pend_row = bus.rf_row_o;
    endtask

    // Expected outputs k cycles after an accepted start, grant always high, ff_ready high at handoff.
    task automatic check_std(input string tag, input int k, input sa_instr_t ins);
        chk($sformatf("%s_req_k%0d", tag, k), 128'(bus.rf_req_o), 128'(k >= 1 && k <= 4));
        if (k >= 1 && k <= 4) begin
            chk($sformatf("%s_row_k%0d", tag, k), 128'(bus.rf_row_o), 128'(k - 1));
            chk($sformatf("%s_reg_k%0d", tag, k), 128'(bus.rf_reg_o), 128'(ins.rs2));
        end
        chk($sformatf("%s_wv_k%0d", tag, k), 128'(bus.weight_valid_o), 128'(k >= 2 && k <= 5));
        if (k >= 2 && k <= 5) begin
            chk($sformatf("%s_wrow_k%0d", tag, k), 128'(bus.weight_row_o), 128'(k - 2));
            chk($sformatf("%s_wdat_k%0d", tag, k), 128'(bus.weight_data_o), rowdat(k - 2));
        end
        chk($sformatf("%s_ffv_k%0d", tag, k), 128'(bus.ff_valid_o), 128'(k == 6));
        if (k == 6) chk($sformatf("%s_ffi_k%0d", tag, k), 128'(bus.ff_instr_o), 128'(ins));
        if (k <= 5) chk($sformatf("%s_wlr_k%0d", tag, k), 128'(bus.wl_ready_o), 128'(0));
    endtask

    initial begin
        sa_instr_t nop, ia, ib, ic, id, ie, ifx, ig, ih;
        int exp_req, nwr;
        logic done;

        nop = '0;
        ia  = '{opcode: 4'h1, rd: 3'd0, rs1: 3'd1, rs2: 3'd3};
        ib  = '{opcode: 4'h2, rd: 3'd1, rs1: 3'd2, rs2: 3'd5};
        ic  = '{opcode: 4'h3, rd: 3'd2, rs1: 3'd3, rs2: 3'd6};
        id  = '{opcode: 4'h4, rd: 3'd3, rs1: 3'd4, rs2: 3'd1};
        ie  = '{opcode: 4'h5, rd: 3'd4, rs1: 3'd5, rs2: 3'd7};
        ifx = '{opcode: 4'h6, rd: 3'd5, rs1: 3'd6, rs2: 3'd2};
        ig  = '{opcode: 4'h7, rd: 3'd6, rs1: 3'd7, rs2: 3'd4};
        ih  = '{opcode: 4'h8, rd: 3'd7, rs1: 3'd0, rs2: 3'd6};

        bus.start_i     = 1'b0;
        bus.instr_i     = '0;
        bus.rf_gnt_i    = 1'b0;
        bus.ff_ready_i  = 1'b0;
        bus.rf_rvalid_i = 1'b0;
        bus.rf_rdata_i  = '0;

        // Reset state.
        do_cycle(1'b1, 1'b0, nop, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b0, nop, 1'b0, 1'b0, 1'b0);
        chk("rst_wlr",  128'(bus.wl_ready_o),     128'(0));
        chk("rst_req",  128'(bus.rf_req_o),       128'(0));
        chk("rst_wv",   128'(bus.weight_valid_o), 128'(0));
        chk("rst_ffv",  128'(bus.ff_valid_o),     128'(0));
        chk("rst_ffi",  128'(bus.ff_instr_o),     128'(0));
        do_cycle(1'b0, 1'b0, nop, 1'b1, 1'b1, 1'b0);
        chk("post_rst_wlr", 128'(bus.wl_ready_o), 128'(1));

        // Single instruction, no stalls.
        do_cycle(1'b0, 1'b1, ia, 1'b1, 1'b1, 1'b0);
        chk("a_start_wlr", 128'(bus.wl_ready_o), 128'(1));
        for (int k = 1; k <= 6; k++) begin
            do_cycle(1'b0, 1'b0, nop, 1'b1, 1'b1, 1'b0);
            check_std("a", k, ia);
        end
        do_cycle(1'b0, 1'b0, nop, 1'b1, 1'b1, 1'b0);
        chk("a_idle_wlr", 128'(bus.wl_ready_o), 128'(1));
        chk("a_idle_ffv", 128'(bus.ff_valid_o), 128'(0));

        // Grant low every other cycle.
        do_cycle(1'b0, 1'b1, ia, 1'b1, 1'b1, 1'b0);
        exp_req = 0;
        nwr     = 0;
        done    = 1'b0;
        for (int k = 1; k <= 30 && !done; k++) begin
            logic g;
            g = (k % 2 == 1);
            do_cycle(1'b0, 1'b0, nop, g, 1'b1, 1'b0);
            if (bus.rf_req_o && g) begin
                chk("gs_req_row", 128'(bus.rf_row_o), 128'(exp_req));
                exp_req++;
            end
            if (bus.weight_valid_o) begin
                chk("gs_wrow", 128'(bus.weight_row_o), 128'(nwr));
                chk("gs_wdat", 128'(bus.weight_data_o), rowdat(nwr));
                nwr++;
            end
            if (bus.ff_valid_o) begin
                chk("gs_writes_at_ffv", 128'(nwr), 128'(4));
                done = 1'b1;
            end
        end
        chk("gs_ffv_seen", 128'(done), 128'(1));
        chk("gs_req_total", 128'(exp_req), 128'(4));
        do_cycle(1'b0, 1'b0, nop, 1'b1, 1'b1, 1'b0);

        // FF stage stalls for 5 cycles; start pulses meanwhile are ignored.
        do_cycle(1'b0, 1'b1, ib, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            do_cycle(1'b0, 1'b0, nop, 1'b1, 1'b0, 1'b0);
            check_std("b", k, ib);
        end
        for (int k = 6; k <= 10; k++) begin
            do_cycle(1'b0, 1'b1, ic, 1'b1, 1'b0, 1'b0);
            chk($sformatf("stall_ffv_k%0d", k), 128'(bus.ff_valid_o), 128'(1));
            chk($sformatf("stall_ffi_k%0d", k), 128'(bus.ff_instr_o), 128'(ib));
            chk($sformatf("stall_wlr_k%0d", k), 128'(bus.wl_ready_o), 128'(0));
        end
        do_cycle(1'b0, 1'b0, nop, 1'b1, 1'b1, 1'b0);
        chk("stall_rel_ffv", 128'(bus.ff_valid_o), 128'(1));
        chk("stall_rel_wlr", 128'(bus.wl_ready_o), 128'(1));
        do_cycle(1'b0, 1'b0, nop, 1'b1, 1'b1, 1'b0);
        chk("stall_after_ffv", 128'(bus.ff_valid_o), 128'(0));
        chk("stall_after_req", 128'(bus.rf_req_o),   128'(0));
        chk("stall_after_ffi", 128'(bus.ff_instr_o), 128'(ib));

        // Back-to-back: second start taken in the HANDOFF cycle.
        do_cycle(1'b0, 1'b1, id, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            do_cycle(1'b0, 1'b0, nop, 1'b1, 1'b1, 1'b0);
            check_std("d", k, id);
        end
        do_cycle(1'b0, 1'b1, ie, 1'b1, 1'b1, 1'b0);
        check_std("d", 6, id);
        chk("b2b_wlr", 128'(bus.wl_ready_o), 128'(1));
        for (int k = 1; k <= 6; k++) begin
            do_cycle(1'b0, 1'b0, nop, 1'b1, 1'b1, 1'b0);
            check_std("e", k, ie);
        end

        // Stray response in IDLE, then one with nothing outstanding in LOAD, then one in HANDOFF.
        do_cycle(1'b0, 1'b0, nop, 1'b1, 1'b1, 1'b1);
        chk("stray_idle_wv",  128'(bus.weight_valid_o), 128'(0));
        chk("stray_idle_wlr", 128'(bus.wl_ready_o),     128'(1));
        do_cycle(1'b0, 1'b1, ifx, 1'b1, 1'b1, 1'b0);
        do_cycle(1'b0, 1'b0, nop, 1'b0, 1'b1, 1'b1);
        chk("stray_load_wv",  128'(bus.weight_valid_o), 128'(0));
        chk("stray_load_req", 128'(bus.rf_req_o),       128'(1));
        chk("stray_load_row", 128'(bus.rf_row_o),       128'(0));
        for (int k = 2; k <= 7; k++) begin
            do_cycle(1'b0, 1'b0, nop, 1'b1, 1'b1, (k == 7));
            check_std("f", k - 1, ifx);
        end

        // Reset after two responses, then a fresh full load.
        do_cycle(1'b0, 1'b1, ig, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            do_cycle(1'b0, 1'b0, nop, 1'b1, 1'b1, 1'b0);
            check_std("g", k, ig);
        end
        do_cycle(1'b1, 1'b0, nop, 1'b1, 1'b1, 1'b0);
        chk("mid_rst_wlr", 128'(bus.wl_ready_o), 128'(0));
        do_cycle(1'b0, 1'b0, nop, 1'b1, 1'b1, 1'b0);
        chk("mid_rst_after_wlr", 128'(bus.wl_ready_o),     128'(1));
        chk("mid_rst_after_req", 128'(bus.rf_req_o),       128'(0));
        chk("mid_rst_after_ffv", 128'(bus.ff_valid_o),     128'(0));
        chk("mid_rst_after_ffi", 128'(bus.ff_instr_o),     128'(0));
        chk("mid_rst_stray_wv",  128'(bus.weight_valid_o), 128'(0));
        do_cycle(1'b0, 1'b1, ih, 1'b1, 1'b1, 1'b0);
        chk("h_start_wlr", 128'(bus.wl_ready_o), 128'(1));
        for (int k = 1; k <= 6; k++) begin
            do_cycle(1'b0, 1'b0, nop, 1'b1, 1'b1, 1'b0);
            check_std("h", k, ih);
        end
        do_cycle(1'b0, 1'b0, nop, 1'b1, 1'b1, 1'b0);
        chk("h_idle_wlr", 128'(bus.wl_ready_o), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
